// File: rtl/fifo_arb_ctrl.sv
// Fill/drain ping-pong controller for a single-clock FIFO: round-robin write
// arbitration of two producers and a burst-drain FSM on the read side.
module fifo_arb_ctrl #(
  parameter int          DATA_W   = 8,
  parameter int          AW       = 8,
  parameter int unsigned DRAIN_TH = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              s0_valid,
  input  logic [DATA_W-1:0] s0_data,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [DATA_W-1:0] s1_data,
  output logic              s1_ready,
  input  logic              flush_req,
  output logic              fifo_wr_req,
  output logic [DATA_W-1:0] fifo_wr_data,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [AW-1:0]     fifo_usedw,
  output logic              fifo_rd_req,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              drain_busy,
  output logic [AW:0]       drain_cnt
);

  localparam logic [AW-1:0] DRAIN_LVL = AW'(DRAIN_TH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_FLUSH
  } state_t;

  state_t            state;
  logic              rr_last;
  logic              flush_pend;
  logic [AW:0]       word_cnt_p0;
  logic [DATA_W-1:0] m_data_p0;

  logic wr_en;
  logic grant0;
  logic grant1;
  logic flush_eff;
  logic start_drain;

  // Write arbiter: producer 1 wins a contention only when producer 0 went last.
  assign wr_en        = sys_rst_n & (state == S_IDLE) & ~fifo_full;
  assign grant1       = s1_valid & (~s0_valid | ~rr_last);
  assign grant0       = s0_valid & ~grant1;
  assign s0_ready     = wr_en & grant0;
  assign s1_ready     = wr_en & grant1;
  assign fifo_wr_req  = wr_en & (s0_valid | s1_valid);
  assign fifo_wr_data = fifo_wr_req ? (grant1 ? s1_data : s0_data) : '0;

  // A flush pulse arriving in IDLE starts the drain on the very next edge.
  assign flush_eff   = flush_pend | flush_req;
  assign start_drain = fifo_full | (fifo_usedw >= DRAIN_LVL) | (flush_eff & ~fifo_empty);

  assign fifo_rd_req = sys_rst_n & (state == S_DRAIN) & ~fifo_empty;
  assign drain_busy  = sys_rst_n & (state != S_IDLE);

  // Read data returns the cycle after rd_req: pass it through while m_valid is
  // high so it lines up with the beat, and keep the last word afterwards.
  assign m_data = m_valid ? fifo_rd_data : m_data_p0;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= S_IDLE;
      rr_last     <= 1'b1;
      flush_pend  <= 1'b0;
      word_cnt_p0 <= '0;
      drain_cnt   <= '0;
      m_valid     <= 1'b0;
      m_data_p0   <= '0;
    end else begin
      m_valid <= fifo_rd_req;
      if (m_valid) begin
        m_data_p0 <= fifo_rd_data;
      end
      if (fifo_wr_req) begin
        rr_last <= grant1;
      end

      case (state)
        S_IDLE: begin
          if (start_drain) begin
            state       <= S_DRAIN;
            word_cnt_p0 <= '0;
            flush_pend  <= 1'b0;
          end else if (fifo_empty) begin
            flush_pend <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (flush_req) begin
            flush_pend <= 1'b1;
          end
          if (fifo_rd_req) begin
            word_cnt_p0 <= word_cnt_p0 + (AW+1)'(1);
          end else begin
            state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (flush_req) begin
            flush_pend <= 1'b1;
          end
          drain_cnt <= word_cnt_p0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
